// File: rtl/flag_cond_pkg.sv
// flag_cond_pkg: flag bit positions, condition codes and FSM encoding for flag_cond_unit
package flag_cond_pkg;
  localparam int FLG_LT = 3;
  localparam int FLG_EQ = 2;
  localparam int FLG_LTS = 1;
  localparam int FLG_V = 0;
  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_LT = 3'd2,
    COND_GE = 3'd3,
    COND_LE = 3'd4,
    COND_GT = 3'd5,
    COND_VS = 3'd6,
    COND_AL = 3'd7
  } cond_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/flag_cond_if.sv
// flag_cond_if: compare-issue, flag-write, branch request and result signals of flag_cond_unit
interface flag_cond_if;
  logic cmp_issue, cmp_ready, flags_we;
  logic [3:0] flags_in, flags_q;
  logic br_valid, br_ready;
  logic [2:0] br_cond;
  logic res_valid, res_ready, res_taken;
  modport master (
    output cmp_issue, flags_we, flags_in, br_valid, br_cond, res_ready,
    input cmp_ready, flags_q, br_ready, res_valid, res_taken
  );
  modport slave (
    input cmp_issue, flags_we, flags_in, br_valid, br_cond, res_ready,
    output cmp_ready, flags_q, br_ready, res_valid, res_taken
  );
endinterface

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational condition-code evaluation over a 4-bit compare flag word
module flag_cond_eval
  import flag_cond_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic [7:0] t;
  logic unused_lts;
  assign unused_lts = flags[FLG_LTS];
  always_comb begin
    t = '0;
    t[COND_EQ] = flags[FLG_EQ];
    t[COND_NE] = ~flags[FLG_EQ];
    t[COND_LT] = flags[FLG_LT];
    t[COND_GE] = ~flags[FLG_LT];
    t[COND_LE] = flags[FLG_LT] | flags[FLG_EQ];
    t[COND_GT] = ~flags[FLG_LT] & ~flags[FLG_EQ];
    t[COND_VS] = flags[FLG_V];
    t[COND_AL] = 1'b1;
    taken = t[cond];
  end
endmodule

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: flag capture, pending-compare scoreboard and branch-condition FSM.
// Define FLAG_BYPASS_EN to forward flags_in into evaluation when the last pending compare completes.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input logic clk,
  input logic rst,
  flag_cond_if.slave bus
);
  localparam int PW = $clog2(MAX_PEND + 1);
  logic [PW-1:0] pending;
  logic [3:0] flags_r;
  logic [2:0] cond_q, cond_sel;
  logic res_r, issue, accept, bypass, take, take_q;
  state_e state, state_n;
  assign issue = bus.cmp_issue & bus.cmp_ready;
  assign accept = (state == IDLE) & bus.br_valid;
  assign bus.cmp_ready = pending < PW'(MAX_PEND);
  assign bus.flags_q = flags_r;
  assign bus.res_taken = res_r;
  // flags_we with nothing pending is a protocol error: counter holds at zero
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else if (issue & ~bus.flags_we) pending <= pending + PW'(1);
    else if (~issue & bus.flags_we & (pending != '0)) pending <= pending - PW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) flags_r <= FLAGS_RST;
    else if (bus.flags_we) flags_r <= bus.flags_in;
  end
  assign cond_sel = (state == IDLE) ? bus.br_cond : cond_q;
  flag_cond_eval u_eval (.cond(cond_sel), .flags(flags_r), .taken(take_q));
`ifdef FLAG_BYPASS_EN
  logic take_b;
  flag_cond_eval u_byp (.cond(cond_q), .flags(bus.flags_in), .taken(take_b));
  assign bypass = (state == WAIT) & bus.flags_we & (pending == PW'(1)) & ~issue;
  assign take = bypass ? take_b : take_q;
`else
  assign bypass = 1'b0;
  assign take = take_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = bus.br_valid ? (((pending == '0) | (bus.br_cond == COND_AL)) ? RESP : WAIT) : IDLE;
    else if (state == WAIT) state_n = ((pending == '0) | bypass) ? RESP : WAIT;
    else state_n = bus.res_ready ? IDLE : RESP;
  end
  always_comb begin
    bus.br_ready = state == IDLE;
    bus.res_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q <= '0;
      res_r <= 1'b0;
    end else begin
      if (accept) cond_q <= bus.br_cond;
      if ((state != RESP) & (state_n == RESP)) res_r <= take;
    end
  end
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: directed stimulus with a scoreboard queue checked by an independent result monitor
module tb_flag_cond_unit;
  import flag_cond_pkg::*;
`ifdef FLAG_BYPASS_EN
  localparam int WLAT = 1;
`else
  localparam int WLAT = 2;
`endif
  logic clk = 1'b0, rst = 1'b1;
  flag_cond_if bus ();
  flag_cond_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (sbq.size() == 0) check("unexpected_result", 32'(bus.res_valid), 32'd0);
      else begin
        check("res_taken", 32'(bus.res_taken), 32'(sbq[0]));
        if (bus.res_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmp(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cmp_issue = 1'b1;
      tick();
    end
    bus.cmp_issue = 1'b0;
  endtask

  task automatic write_flags(input logic [3:0] f);
    bus.flags_we = 1'b1;
    bus.flags_in = f;
    tick();
    bus.flags_we = 1'b0;
    bus.flags_in = 4'bxxxx;
  endtask

  task automatic compare(input logic [3:0] f);
    issue_cmp(1);
    write_flags(f);
    check("flags_q", 32'(bus.flags_q), 32'(f));
  endtask

  task automatic wait_resp(input string name, input int lat);
    int l = 1;
    while (!bus.res_valid && l < 20) begin
      tick();
      l++;
    end
    check(name, l, lat);
  endtask

  task automatic finish_resp(input int hold);
    for (int i = 0; i < hold; i++) tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_valid_after_ack", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic request(input logic [2:0] c, input logic exp);
    int n = 0;
    sbq.push_back(exp);
    bus.br_valid = 1'b1;
    bus.br_cond = c;
    while (!bus.br_ready && n < 20) begin
      tick();
      n++;
    end
    check("br_ready_wait", 32'(bus.br_ready), 32'd1);
    tick();
    bus.br_valid = 1'b0;
  endtask

  task automatic branch(input logic [2:0] c, input logic exp, input int hold);
    request(c, exp);
    wait_resp("latency_idle", 1);
    finish_resp(hold);
  endtask

  task automatic reset_check();
    rst = 1'b1;
    sbq.delete();
    tick();
    rst = 1'b0;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_taken", 32'(bus.res_taken), 32'd0);
    check("rst_br_ready", 32'(bus.br_ready), 32'd1);
    check("rst_cmp_ready", 32'(bus.cmp_ready), 32'd1);
    check("rst_flags_q", 32'(bus.flags_q), 32'd0);
  endtask

  initial begin
    bus.cmp_issue = 1'b0;
    bus.flags_we = 1'b0;
    bus.flags_in = 4'bxxxx;
    bus.br_valid = 1'b0;
    bus.br_cond = 3'd0;
    bus.res_ready = 1'b0;
    tick();
    reset_check();
    // 1: 5-7 -> LT set
    compare(4'b1010);
    branch(COND_LT, 1'b1, 0);
    branch(COND_GE, 1'b0, 0);
    // 2: 7-7 -> EQ set, results held for 3 cycles
    compare(4'b0100);
    branch(COND_EQ, 1'b1, 3);
    branch(COND_LE, 1'b1, 3);
    branch(COND_GT, 1'b0, 3);
    branch(COND_NE, 1'b0, 3);
    // 3: stall behind two compares
    issue_cmp(2);
    request(COND_EQ, 1'b1);
    check("stall_br_ready", 32'(bus.br_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_res_valid", 32'(bus.res_valid), 32'd0);
      tick();
    end
    write_flags(4'b1000);
    check("stall_after_1st", 32'(bus.res_valid), 32'd0);
    write_flags(4'b0100);
    wait_resp("latency_wait", WLAT);
    finish_resp(0);
    // bypass is blocked by a same-cycle issue
    issue_cmp(1);
    request(COND_EQ, 1'b1);
    bus.cmp_issue = 1'b1;
    write_flags(4'b0100);
    bus.cmp_issue = 1'b0;
    check("blocked_bypass", 32'(bus.res_valid), 32'd0);
    tick();
    check("blocked_bypass2", 32'(bus.res_valid), 32'd0);
    write_flags(4'b0100);
    wait_resp("latency_wait2", WLAT);
    finish_resp(0);
    // 4: full scoreboard
    issue_cmp(4);
    check("full_cmp_ready", 32'(bus.cmp_ready), 32'd0);
    issue_cmp(1);
    write_flags(4'b0001);
    check("after_drain_ready", 32'(bus.cmp_ready), 32'd1);
    bus.cmp_issue = 1'b1;
    write_flags(4'b0001);
    bus.cmp_issue = 1'b0;
    check("issue_and_we_ready", 32'(bus.cmp_ready), 32'd1);
    issue_cmp(1);
    check("refull_cmp_ready", 32'(bus.cmp_ready), 32'd0);
    // 5: overflow, AL with 3 pending
    write_flags(4'b0001);
    check("flags_v", 32'(bus.flags_q), 32'd1);
    branch(COND_AL, 1'b1, 0);
    for (int i = 0; i < 3; i++) write_flags(4'b0001);
    branch(COND_VS, 1'b1, 0);
    // flags_we with nothing pending: captured, counter stays at zero
    write_flags(4'b1000);
    check("flags_no_pend", 32'(bus.flags_q), 32'h8);
    issue_cmp(1);
    request(COND_EQ, 1'b1);
    check("sat_stall", 32'(bus.res_valid), 32'd0);
    write_flags(4'b0100);
    wait_resp("latency_sat", WLAT);
    finish_resp(0);
    // 6: reset in WAIT, then in RESP
    issue_cmp(1);
    request(COND_EQ, 1'b0);
    check("in_wait", 32'(bus.br_ready), 32'd0);
    reset_check();
    branch(COND_EQ, 1'b0, 0);
    compare(4'b0100);
    request(COND_EQ, 1'b1);
    check("in_resp", 32'(bus.res_valid), 32'd1);
    tick();
    reset_check();
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
